// File: rtl/mem_bank_ctrl.sv
// Load/store controller in front of a two-bank memory: registers bank select/address/data,
// strobes the per-bank write enable and returns load data after READ_LAT cycles.
// Optional BANK_ACCESS_CNT_EN enables saturating per-bank access counters.
module mem_bank_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              bank_sel,
  output logic [DATA_W-1:0] bank_wdata,
  output logic [ADDR_W-2:0] bank_addr,
  output logic              bank_we0,
  output logic              bank_we1,
  input  logic [DATA_W-1:0] bank_rdata0,
  input  logic [DATA_W-1:0] bank_rdata1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [15:0]       acc_cnt0,
  output logic [15:0]       acc_cnt1
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ_WAIT, S_RESP} state_e;

  localparam logic [3:0] LAT_INIT = 4'(READ_LAT - 1);

  state_e              state_q, state_d;
  logic [3:0]          lat_q, lat_d;
  logic                sel_q, sel_d;
  logic [ADDR_W-2:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: every signal gets a hold default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          sel_d   = req_addr[ADDR_W-1];
          addr_d  = req_addr[ADDR_W-2:0];
          wdata_d = req_wdata;
          if (req_we) begin
            state_d = S_WRITE;
          end else begin
            lat_d   = LAT_INIT;
            state_d = S_READ_WAIT;
          end
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ_WAIT: begin
        if (lat_q == 4'd0) begin
          rdata_d = sel_q ? bank_rdata1 : bank_rdata0;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    rsp_valid = (state_q == S_RESP);
    bank_we0  = (state_q == S_WRITE) && !sel_q;
    bank_we1  = (state_q == S_WRITE) &&  sel_q;
  end

  assign bank_sel   = sel_q;
  assign bank_addr  = addr_q;
  assign bank_wdata = wdata_q;
  assign rsp_rdata  = rdata_q;

`ifdef BANK_ACCESS_CNT_EN
  logic [15:0] cnt0_q, cnt1_q;
  logic        done;

  // An access completes in its strobe cycle (store) or on the response handshake (load).
  always_comb begin
    done = (state_q == S_WRITE) || ((state_q == S_RESP) && rsp_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (done && !sel_q && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
      if (done &&  sel_q && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign acc_cnt0 = cnt0_q;
  assign acc_cnt1 = cnt1_q;
`else
  assign acc_cnt0 = 16'd0;
  assign acc_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Bench for mem_bank_ctrl: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_bank_ctrl;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int READ_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] bank_rdata0 = '0;
  logic [15:0] bank_rdata1 = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready, bank_sel, bank_we0, bank_we1, rsp_valid, busy;
  logic [15:0] bank_wdata, rsp_rdata, acc_cnt0, acc_cnt1;
  logic [14:0] bank_addr;

  int n_checks = 0;
  int n_pass   = 0;

  mem_bank_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .bank_sel(bank_sel), .bank_wdata(bank_wdata), .bank_addr(bank_addr),
    .bank_we0(bank_we0), .bank_we1(bank_we1),
    .bank_rdata0(bank_rdata0), .bank_rdata1(bank_rdata1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .acc_cnt0(acc_cnt0), .acc_cnt1(acc_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: one outstanding transaction, tracked by its age in cycles since acceptance.
  logic        m_active = 1'b0;
  logic        m_store = 1'b0;
  logic        m_sel = 1'b0;
  int          m_age = 0;
  logic [14:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;
  logic [15:0] m_cnt0 = '0;
  logic [15:0] m_cnt1 = '0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_store = 1'b0; m_sel = 1'b0; m_age = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_cnt0 = '0; m_cnt1 = '0;
    end else if (!m_active) begin
      if (req_valid) begin
        m_active = 1'b1;
        m_store  = req_we;
        m_sel    = req_addr[15];
        m_addr   = req_addr[14:0];
        m_wdata  = req_wdata;
        m_age    = 1;
      end
    end else if (m_store) begin
      if (m_sel) m_cnt1 = sat_inc(m_cnt1); else m_cnt0 = sat_inc(m_cnt0);
      m_active = 1'b0;
    end else begin
      if (m_age == READ_LAT) m_rdata = m_sel ? bank_rdata1 : bank_rdata0;
      if (m_age > READ_LAT && rsp_ready) begin
        if (m_sel) m_cnt1 = sat_inc(m_cnt1); else m_cnt0 = sat_inc(m_cnt0);
        m_active = 1'b0;
      end
      m_age++;
    end
  end

  always @(negedge clk) begin
    check("req_ready", req_ready, !m_active);
    check("busy", busy, m_active);
    check("bank_sel", bank_sel, m_sel);
    check("bank_addr", bank_addr, m_addr);
    check("bank_wdata", bank_wdata, m_wdata);
    check("bank_we0", bank_we0, m_active && m_store && !m_sel);
    check("bank_we1", bank_we1, m_active && m_store && m_sel);
    check("rsp_valid", rsp_valid, m_active && !m_store && (m_age > READ_LAT));
    check("rsp_rdata", rsp_rdata, m_rdata);
`ifdef BANK_ACCESS_CNT_EN
    check("acc_cnt0", acc_cnt0, m_cnt0);
    check("acc_cnt1", acc_cnt1, m_cnt1);
`else
    check("acc_cnt0", acc_cnt0, 16'd0);
    check("acc_cnt1", acc_cnt1, 16'd0);
`endif
  end

  // Called just after a rising edge; returns just after the accepting edge (cycle N+1).
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    bit seen = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (req_ready) seen = 1;
    end
    if (!seen) check("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    if (!seen) check("rsp_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Store to bank 1
    do_req(1'b1, 16'h8005, 16'hABCD);
    @(negedge clk);
    check("st1_sel", bank_sel, 1);
    check("st1_addr", bank_addr, 15'h0005);
    check("st1_wdata", bank_wdata, 16'hABCD);
    check("st1_we1", bank_we1, 1);
    check("st1_we0", bank_we0, 0);
    check("st1_ready_low", req_ready, 0);
    @(negedge clk);
    check("st1_we1_off", bank_we1, 0);
    check("st1_ready_back", req_ready, 1);
    @(posedge clk); #1;

    // Store to bank 0
    do_req(1'b1, 16'h0003, 16'h1234);
    @(negedge clk);
    check("st0_we0", bank_we0, 1);
    check("st0_we1", bank_we1, 0);
    check("st0_sel", bank_sel, 0);
    check("st0_ready_low", req_ready, 0);
    @(negedge clk);
    check("st0_ready_back", req_ready, 1);
    @(posedge clk); #1;

    // Load from bank 1; bank data changes each cycle to pin the capture edge
    rsp_ready = 1'b1;
    bank_rdata0 = 16'hFFFF;
    bank_rdata1 = 16'h1111;
    do_req(1'b0, 16'h8010, 16'h0000);
    @(negedge clk);
    check("ld_n1_valid", rsp_valid, 0);
    @(posedge clk); #1;
    bank_rdata1 = 16'h5A5A;
    @(negedge clk);
    check("ld_n2_valid", rsp_valid, 0);
    @(posedge clk); #1;
    bank_rdata1 = 16'h2222;
    @(negedge clk);
    check("ld_n3_valid", rsp_valid, 1);
    check("ld_n3_rdata", rsp_rdata, 16'h5A5A);
    @(negedge clk);
    check("ld_n4_ready", req_ready, 1);
    check("ld_n4_valid", rsp_valid, 0);
    @(posedge clk); #1;

    // Same load with consumer stalled four cycles
    bank_rdata1 = 16'h5A5A;
    rsp_ready = 1'b0;
    do_req(1'b0, 16'h8010, 16'h0000);
    wait_rsp();
    check("stall_rdata0", rsp_rdata, 16'h5A5A);
    bank_rdata1 = 16'h0BAD;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", rsp_valid, 1);
      check("stall_rdata", rsp_rdata, 16'h5A5A);
      check("stall_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hs_valid", rsp_valid, 1);
    check("hs_ready", req_ready, 0);
    @(negedge clk);
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_ready", req_ready, 1);
    @(posedge clk); #1;

    // Reset during READ_WAIT
    do_req(1'b0, 16'h8010, 16'h0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_req_ready", req_ready, 1);
    check("mr_busy", busy, 0);
    check("mr_sel", bank_sel, 0);
    check("mr_addr", bank_addr, 0);
    check("mr_wdata", bank_wdata, 0);
    check("mr_rdata", rsp_rdata, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_cnt0", acc_cnt0, 0);
    check("mr_cnt1", acc_cnt1, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("mr_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;

    // Counter scenario: 3 stores to bank 0, 2 loads from bank 1
    for (int i = 1; i <= 3; i++) do_req(1'b1, 16'(i), 16'(16'h100 + i));
    for (int i = 1; i <= 2; i++) begin
      do_req(1'b0, 16'(16'h8000 + i), 16'h0000);
      wait_rsp();
      @(posedge clk); #1;
    end
    repeat (2) @(negedge clk);
`ifdef BANK_ACCESS_CNT_EN
    check("cnt0_lit", acc_cnt0, 16'd3);
    check("cnt1_lit", acc_cnt1, 16'd2);
`else
    check("cnt0_lit", acc_cnt0, 16'd0);
    check("cnt1_lit", acc_cnt1, 16'd0);
`endif

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
